// File: rtl/sts_capture.sv
// sts_capture: per-event counters with a coherent snapshot for the AXI status block.
// Live counters saturate at 2^CNT_WIDTH-1 and set sticky flags. A rising snap_req
// loads the shadow counters and flags, bumps the 16-bit sequence number and pulses
// snap_done. sts_data word 0 = {seq, sat flags}; word i = shadow count of event i-1.
// Optional build macro: STS_CAPTURE_CLEAR_ON_SNAP_EN restarts the live counting
// window on every snapshot (read-and-clear). When it is undefined the counters
// run freely across snapshots.
module sts_capture #(
    parameter int NUM_EVENTS     = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int STS_DATA_WIDTH = (NUM_EVENTS + 1) * 32
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_EVENTS-1:0]     event_in,
    input  logic                      snap_req,
    input  logic                      cnt_clear,
    output logic                      snap_done,
    output logic [STS_DATA_WIDTH-1:0] sts_data
);

    localparam int                   BUS_W   = (NUM_EVENTS + 1) * CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 snap_req_q;
    logic                 snap_armed;
    logic                 snap_edge;
    logic                 window_restart;
    logic [CNT_WIDTH-1:0] live_cnt   [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] live_sat;
    logic [CNT_WIDTH-1:0] shadow_cnt [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] shadow_sat;
    logic [15:0]          seq_num;
    logic [15:0]          sat_field;
    logic [BUS_W-1:0]     sts_bus;

    // snap_armed stays low until snap_req has been seen low after reset, so a
    // request level held through reset release cannot fire a snapshot.
    assign snap_edge = snap_req & ~snap_req_q & snap_armed;

`ifdef STS_CAPTURE_CLEAR_ON_SNAP_EN
    assign window_restart = snap_edge;
`else
    assign window_restart = 1'b0;
`endif

    // snap_req history and post-reset arming
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            snap_req_q <= 1'b0;
            snap_armed <= 1'b0;
        end else begin
            snap_req_q <= snap_req;
            if (!snap_req) begin
                snap_armed <= 1'b1;
            end
        end
    end

    // live saturating counters; clear wins over events, a window restart keeps the
    // event of the snapshot edge itself as the first count of the new window
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                live_cnt[i] <= '0;
            end
            live_sat <= '0;
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (cnt_clear) begin
                    live_cnt[i] <= '0;
                    live_sat[i] <= 1'b0;
                end else if (window_restart) begin
                    live_cnt[i] <= CNT_WIDTH'(event_in[i]);
                    live_sat[i] <= 1'b0;
                end else if (event_in[i] && (live_cnt[i] != CNT_MAX)) begin
                    live_cnt[i] <= live_cnt[i] + CNT_ONE;
                    if (live_cnt[i] == (CNT_MAX - CNT_ONE)) begin
                        live_sat[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // shadow capture of pre-update live values, sequence number and done pulse
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                shadow_cnt[i] <= '0;
            end
            shadow_sat <= '0;
            seq_num    <= '0;
            snap_done  <= 1'b0;
        end else begin
            snap_done <= snap_edge;
            if (snap_edge) begin
                for (int i = 0; i < NUM_EVENTS; i++) begin
                    shadow_cnt[i] <= live_cnt[i];
                end
                shadow_sat <= live_sat;
                seq_num    <= seq_num + 16'd1;
            end
        end
    end

    // flags occupy the low bits of the 16-bit field, the rest reads zero
    always_comb begin
        sat_field                   = '0;
        sat_field[NUM_EVENTS-1:0]   = shadow_sat;
    end

    assign sts_bus[CNT_WIDTH-1:0] = CNT_WIDTH'({seq_num, sat_field});

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_word
        assign sts_bus[CNT_WIDTH*(g+1) +: CNT_WIDTH] = shadow_cnt[g];
    end

    assign sts_data = STS_DATA_WIDTH'(sts_bus);

endmodule

// File: tb/tb_sts_capture.sv
// Directed bench for sts_capture: reset, basic snapshot, held request,
// saturation, clear/snapshot collision, counting window and async reset + wrap.
module tb_sts_capture;

    localparam int NE = 4;
    localparam int SW = (NE + 1) * 32;

    logic          aclk = 1'b0;
    logic          areset = 1'b0;
    logic [NE-1:0] event_in = '0;
    logic          snap_req = 1'b0;
    logic          cnt_clear = 1'b0;
    logic          snap_done;
    logic [SW-1:0] sts_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    sts_capture #(
        .NUM_EVENTS    (NE),
        .CNT_WIDTH     (32),
        .STS_DATA_WIDTH(SW)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .event_in (event_in),
        .snap_req (snap_req),
        .cnt_clear(cnt_clear),
        .snap_done(snap_done),
        .sts_data (sts_data)
    );

    function automatic logic [31:0] word(input int i);
        return sts_data[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic clear_live();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
    endtask

    task automatic test_reset();
        #2 areset = 1'b1;
        #1;
        n_checks++;
        if (sts_data !== '0) begin
            n_fail++; $display("FAIL reset_sts: got %h expected 0", sts_data);
        end
        n_checks++;
        if (snap_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b expected 0", snap_done);
        end
        @(negedge aclk);
        tick();
        areset = 1'b0;
        tick();
        n_checks++;
        if (sts_data !== '0 || snap_done !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: sts %h done %b expected 0/0", sts_data, snap_done);
        end
    endtask

    task automatic test_basic();
        event_in = 4'b0001;
        repeat (10) tick();
        event_in = '0;
        snap_req = 1'b1;
        tick();
        n_checks++;
        if (snap_done !== 1'b1) begin
            n_fail++; $display("FAIL basic_done: got %b expected 1", snap_done);
        end
        n_checks++;
        if (word(1) !== 32'd10) begin
            n_fail++; $display("FAIL basic_word1: got %0d expected 10", word(1));
        end
        n_checks++;
        if (word(0) !== 32'h0001_0000) begin
            n_fail++; $display("FAIL basic_word0: got %h expected 00010000", word(0));
        end
        tick();
        n_checks++;
        if (snap_done !== 1'b0) begin
            n_fail++; $display("FAIL basic_done_width: got %b expected 0", snap_done);
        end
        snap_req = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        logic [SW-1:0] exp;
        int pulses;
        int frozen_bad;
        exp = {32'd0, 32'd0, 32'd0, 32'd3, 32'h0002_0000};
        pulses = 0;
        frozen_bad = 0;
        clear_live();
        event_in = 4'b0001;
        repeat (3) tick();
        snap_req = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (snap_done === 1'b1) pulses++;
            if (sts_data !== exp) frozen_bad++;
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL hold_pulses: got %0d expected 1", pulses);
        end
        n_checks++;
        if (frozen_bad !== 0) begin
            n_fail++; $display("FAIL hold_frozen: %0d cycles differ, last sts %h expected %h", frozen_bad, sts_data, exp);
        end
        snap_req = 1'b0;
        event_in = '0;
        tick();
    endtask

    task automatic test_saturation();
        clear_live();
        dut.live_cnt[2] = 32'hFFFF_FFFA;
        event_in = 4'b0100;
        repeat (10) tick();
        event_in = '0;
        snap_req = 1'b1;
        tick();
        n_checks++;
        if (word(3) !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sat_word3: got %h expected ffffffff", word(3));
        end
        n_checks++;
        if (word(0) !== 32'h0003_0004) begin
            n_fail++; $display("FAIL sat_word0: got %h expected 00030004", word(0));
        end
        snap_req = 1'b0;
        tick();
        clear_live();
        snap_req = 1'b1;
        tick();
        n_checks++;
        if (word(3) !== 32'd0) begin
            n_fail++; $display("FAIL sat_clr_word3: got %h expected 0", word(3));
        end
        n_checks++;
        if (word(0) !== 32'h0004_0000) begin
            n_fail++; $display("FAIL sat_clr_word0: got %h expected 00040000", word(0));
        end
        snap_req = 1'b0;
        tick();
    endtask

    task automatic test_clear_snap();
        clear_live();
        event_in = 4'b0001;
        repeat (7) tick();
        cnt_clear = 1'b1;
        snap_req  = 1'b1;
        tick();
        n_checks++;
        if (word(1) !== 32'd7) begin
            n_fail++; $display("FAIL clrsnap_word1: got %0d expected 7", word(1));
        end
        n_checks++;
        if (word(0) !== 32'h0005_0000) begin
            n_fail++; $display("FAIL clrsnap_word0: got %h expected 00050000", word(0));
        end
        cnt_clear = 1'b0;
        snap_req  = 1'b0;
        event_in  = '0;
        tick();
        snap_req = 1'b1;
        tick();
        n_checks++;
        if (word(1) !== 32'd0) begin
            n_fail++; $display("FAIL clrsnap_next_word1: got %0d expected 0", word(1));
        end
        snap_req = 1'b0;
        tick();
    endtask

    task automatic test_window();
        logic [31:0] exp2;
`ifdef STS_CAPTURE_CLEAR_ON_SNAP_EN
        exp2 = 32'd3;
`else
        exp2 = 32'd8;
`endif
        clear_live();
        event_in = 4'b0001;
        repeat (5) tick();
        snap_req = 1'b1;
        tick();
        n_checks++;
        if (word(1) !== 32'd5) begin
            n_fail++; $display("FAIL window_first: got %0d expected 5", word(1));
        end
        snap_req = 1'b0;
        repeat (2) tick();
        event_in = '0;
        tick();
        snap_req = 1'b1;
        tick();
        n_checks++;
        if (word(1) !== exp2) begin
            n_fail++; $display("FAIL window_second: got %0d expected %0d", word(1), exp2);
        end
        n_checks++;
        if (word(0) !== 32'h0008_0000) begin
            n_fail++; $display("FAIL window_word0: got %h expected 00080000", word(0));
        end
        snap_req = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        int late_pulses;
        late_pulses = 0;
        event_in = 4'b0001;
        snap_req = 1'b1;
        @(posedge aclk);
        #2;
        n_checks++;
        if (snap_done !== 1'b1 || word(0) !== 32'h0009_0000) begin
            n_fail++; $display("FAIL pre_reset: done %b word0 %h expected 1/00090000", snap_done, word(0));
        end
        areset = 1'b1;
        #1;
        n_checks++;
        if (sts_data !== '0) begin
            n_fail++; $display("FAIL async_sts: got %h expected 0", sts_data);
        end
        n_checks++;
        if (snap_done !== 1'b0) begin
            n_fail++; $display("FAIL async_done: got %b expected 0", snap_done);
        end
        @(negedge aclk);
        event_in = '0;
        tick();
        areset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (snap_done !== 1'b0) late_pulses++;
        end
        n_checks++;
        if (late_pulses !== 0 || sts_data !== '0) begin
            n_fail++; $display("FAIL held_through_reset: pulses %0d sts %h expected 0/0", late_pulses, sts_data);
        end
        snap_req = 1'b0;
        tick();
        snap_req = 1'b1;
        tick();
        n_checks++;
        if (snap_done !== 1'b1 || word(0) !== 32'h0001_0000) begin
            n_fail++; $display("FAIL rearm: done %b word0 %h expected 1/00010000", snap_done, word(0));
        end
        snap_req = 1'b0;
        tick();
        dut.seq_num = 16'hFFFE;
        snap_req = 1'b1;
        tick();
        n_checks++;
        if (word(0) !== 32'hFFFF_0000) begin
            n_fail++; $display("FAIL seq_ffff: got %h expected ffff0000", word(0));
        end
        snap_req = 1'b0;
        tick();
        snap_req = 1'b1;
        tick();
        n_checks++;
        if (word(0) !== 32'h0000_0000) begin
            n_fail++; $display("FAIL seq_wrap: got %h expected 00000000", word(0));
        end
        snap_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_saturation();
        test_clear_snap();
        test_window();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sts_capture.md
STS_CAPTURE -- requirements
Module: sts_capture

Interface
REQ-001 SHALL have parameter NUM_EVENTS, default 4, meaning the number of event inputs counted (legal range 1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning the width of each event counter and status word (fixed at 32 for the AXI status word).
REQ-003 SHALL have parameter STS_DATA_WIDTH, default (NUM_EVENTS+1)*32, meaning the width of the status bus driven downstream.
REQ-004 SHALL have port aclk, input, 1 bit: the single clock; all logic is in this domain.
REQ-005 SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port event_in, input, NUM_EVENTS bits: per-cycle event strobes, where each high bit counts one event.
REQ-007 SHALL have port snap_req, input, 1 bit: snapshot request level, typically driven from a control-register bit.
REQ-008 SHALL have port cnt_clear, input, 1 bit: synchronous clear of the live counters.
REQ-009 SHALL have port snap_done, output, 1 bit: one-cycle pulse indicating a snapshot was taken.
REQ-010 SHALL have port sts_data, output, STS_DATA_WIDTH bits: coherent snapshot bus feeding the AXI status register block.

Function
REQ-011 SHALL keep one live counter per event bit; each live counter increments by 1 on every aclk edge where its event_in bit is 1.
REQ-012 Each live counter SHALL saturate at 2^32-1 and SHALL NOT wrap.
REQ-013 Each live counter SHALL set a sticky saturation flag when it reaches 2^32-1.
REQ-014 Snapshot edge = snap_req==1 on the current aclk edge while its registered previous value is 0; a held level SHALL produce exactly one snapshot.
REQ-015 On a snapshot edge, all shadow counters SHALL load the live counter values present before that edge's update, on the same edge.
REQ-016 On a snapshot edge, the shadow saturation flags SHALL load on the same edge.
REQ-017 On a snapshot edge, the 16-bit sequence number SHALL increment on the same edge, wrapping from 0xFFFF to 0x0000.
REQ-018 snap_done SHALL be registered and SHALL be high for exactly the one cycle after the snapshot edge.
REQ-019 sts_data word 0 [31:16] SHALL hold the shadow sequence number.
REQ-020 sts_data word 0 [15:0] SHALL hold the shadow saturation flags in bits [NUM_EVENTS-1:0]; the remaining bits SHALL be zero.
REQ-021 sts_data word i (1..NUM_EVENTS) SHALL hold the shadow count for event i-1.
REQ-022 sts_data SHALL be driven directly from registers and SHALL change only on snapshot edges or reset.
REQ-023 cnt_clear=1 SHALL zero all live counters and saturation flags on that edge; events arriving on the same edge SHALL be discarded.
REQ-024 cnt_clear and a snapshot edge on the same edge: the shadow SHALL capture the pre-clear values, and the live counters SHALL become 0.
REQ-025 cnt_clear SHALL NOT affect the shadow registers or the sequence number.

Reset
REQ-026 Asserting areset SHALL immediately clear all live counters, flags, shadow registers, the sequence number and the snap_req history register.
REQ-027 While areset is asserted, sts_data SHALL be all zeros and snap_done SHALL be 0.
REQ-028 A snap_req held at 1 through reset release SHALL NOT produce a snapshot until it goes low and then high again.

Configuration
REQ-029 Macro STS_CAPTURE_CLEAR_ON_SNAP_EN, when defined, SHALL zero the live counters and flags on every snapshot edge (read-and-clear).
REQ-030 With STS_CAPTURE_CLEAR_ON_SNAP_EN defined, an event on the snapshot edge itself SHALL give a live count of 1 in the new window.
REQ-031 Without STS_CAPTURE_CLEAR_ON_SNAP_EN, the live counters SHALL run freely across snapshots.

Verification
REQ-032 Reset, then 10 pulses on event_in[0] and a snap_req rise -> word1=10, word0=0x00010000, snap_done high for 1 cycle.
REQ-033 Hold snap_req high for 20 cycles while events continue -> exactly one snap_done, and sts_data remains frozen.
REQ-034 Preload live counter 2 near 2^32-1 and run continuous events -> word3=0xFFFFFFFF after a snapshot, word0 bit2=1; then cnt_clear and a second snapshot -> word3=0, bit2=0.
REQ-035 cnt_clear and a snap_req rise on the same edge with count 7 -> word1=7, and the next snapshot with no events -> word1=0.
REQ-036 With the macro defined, 5 events, snapshot, 3 events (one on the snapshot edge), snapshot -> word1=5 then 3; without the macro -> word1=5 then 8.
REQ-037 Assert areset mid-count asynchronously between clock edges -> sts_data=0 and snap_done=0 immediately, and 65536 snapshots then wrap the sequence to 0x0000.
